mult_nibble_seq_ctrl: RTL and testbench

- Sequencing controller that builds a W x W unsigned product by time-multiplexing one external 4x4 unsigned combinational multiplier (mult4u family, 8-bit product) over all nibble pairs.
- Sits between a valid/ready operand producer and a valid/ready result consumer.
- Drives the shared multiplier's operand nibbles, shift-accumulates its product into a 2W-bit accumulator, and holds the result until the consumer accepts it.

---
 rtl/mult_nibble_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_mult_nibble_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_nibble_seq_ctrl.sv
// Sequencing controller: builds a W x W unsigned product by stepping one shared external
// 4x4 multiplier over every nibble pair. Optional zero-operand bypass: MULT_NIBBLE_ZERO_SKIP_EN.
module mult_nibble_seq_ctrl #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic [3:0]     mul_a,
    output logic [3:0]     mul_b,
    input  logic [7:0]     mul_p,
    output logic           mul_en,
    output logic           busy
);

    localparam int NN = W / 4;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int NE = 2 ** IW;
    localparam int PW = 2 * W;
    localparam int SW = $clog2(PW);
    localparam logic [IW-1:0] LAST = IW'(NN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [PW-1:0]   r_acc;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_j;

    logic [3:0]      w_a_nib [NE];
    logic [3:0]      w_b_nib [NE];
    logic            w_accept;
    logic            w_zero_op;
    logic            w_last;
    logic [IW:0]     w_pair_sum;
    logic [SW-1:0]   w_shamt;
    logic [PW-1:0]   w_term;

    // Nibble tables padded to a power of two so the index never selects past the operand.
    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_nib
            if (gi < NN) begin : g_real
                assign w_a_nib[gi] = r_a[4*gi +: 4];
                assign w_b_nib[gi] = r_b[4*gi +: 4];
            end else begin : g_pad
                assign w_a_nib[gi] = 4'h0;
                assign w_b_nib[gi] = 4'h0;
            end
        end
    endgenerate

    assign w_accept = in_valid && (r_state == IDLE);

`ifdef MULT_NIBBLE_ZERO_SKIP_EN
    assign w_zero_op = (in_a == '0) || (in_b == '0);
`else
    assign w_zero_op = 1'b0;
`endif

    assign w_last     = (r_i == LAST) && (r_j == LAST);
    assign w_pair_sum = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt    = SW'({w_pair_sum, 2'b00});
    assign w_term     = PW'(mul_p) << w_shamt;
    assign out_prod   = r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        mul_en       = 1'b0;
        mul_a        = 4'h0;
        mul_b        = 4'h0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) begin
                    w_state_next = w_zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                mul_en = 1'b1;
                mul_a  = w_a_nib[r_i];
                mul_b  = w_b_nib[r_j];
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: i is the outer (multiplicand) index, j the inner (multiplier) index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                RUN: begin
                    r_acc <= r_acc + w_term;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_nibble_seq_ctrl.sv
// Self-checking bench: W=8 and W=16 controllers, each driving an ideal 4x4 multiplier.
module tb_mult_nibble_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       in_valid_v;
    logic [1:0]       out_ready_v;
    logic [1:0][15:0] in_a_v;
    logic [1:0][15:0] in_b_v;
    wire  [1:0]       in_ready_v;
    wire  [1:0]       out_valid_v;
    wire  [1:0]       mul_en_v;
    wire  [1:0]       busy_v;
    wire  [1:0][31:0] out_prod_v;
    wire  [1:0][3:0]  mul_a_v;
    wire  [1:0][3:0]  mul_b_v;
    wire  [1:0][7:0]  mul_p_v;
    wire  [15:0]      prod8;

    int checks = 0;
    int errors = 0;

    assign mul_p_v[0]    = {4'h0, mul_a_v[0]} * {4'h0, mul_b_v[0]};
    assign mul_p_v[1]    = {4'h0, mul_a_v[1]} * {4'h0, mul_b_v[1]};
    assign out_prod_v[0] = {16'h0, prod8};

    mult_nibble_seq_ctrl #(.W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .in_a      (in_a_v[0][7:0]),
        .in_b      (in_b_v[0][7:0]),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .out_prod  (prod8),
        .mul_a     (mul_a_v[0]),
        .mul_b     (mul_b_v[0]),
        .mul_p     (mul_p_v[0]),
        .mul_en    (mul_en_v[0]),
        .busy      (busy_v[0])
    );

    mult_nibble_seq_ctrl #(.W(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .in_a      (in_a_v[1]),
        .in_b      (in_b_v[1]),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .out_prod  (out_prod_v[1]),
        .mul_a     (mul_a_v[1]),
        .mul_b     (mul_b_v[1]),
        .mul_p     (mul_p_v[1]),
        .mul_en    (mul_en_v[1]),
        .busy      (busy_v[1])
    );

    function automatic void chk(input string name, input int k, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s w%0d got=%0h want=%0h", name, (k != 0) ? 16 : 8, act, exp);
        end
    endfunction

    function automatic logic [15:0] rnd(input int k);
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 7) == 0) v = 16'h0;
        return (k != 0) ? v : {8'h00, v[7:0]};
    endfunction

    function automatic int exp_latency(input int k, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = (k != 0) ? 16 : 4;
`ifdef MULT_NIBBLE_ZERO_SKIP_EN
        if (a == 16'h0 || b == 16'h0) n = 0;
`endif
        return n;
    endfunction

    // Transaction-level reference: an accepted pair occupies the unit for lat cycles,
    // then its product is offered until the consumer takes it.
    bit          m_known [2];
    bit          m_act   [2];
    bit          m_clean [2];
    int          m_t     [2];
    int          m_lat   [2];
    logic [15:0] m_a     [2];
    logic [15:0] m_b     [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_known[k] = 1'b0;
            m_act[k]   = 1'b0;
            m_clean[k] = 1'b0;
            m_t[k]     = 0;
            m_lat[k]   = 0;
            m_a[k]     = 16'h0;
            m_b[k]     = 16'h0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_known[k] = 1'b1;
                m_act[k]   = 1'b0;
                m_clean[k] = 1'b1;
            end else if (m_known[k]) begin
                if (!m_act[k]) begin
                    if (in_valid_v[k]) begin
                        m_act[k]   = 1'b1;
                        m_clean[k] = 1'b0;
                        m_t[k]     = 0;
                        m_a[k]     = in_a_v[k];
                        m_b[k]     = in_b_v[k];
                        m_lat[k]   = exp_latency(k, in_a_v[k], in_b_v[k]);
                    end
                end else if (m_t[k] < m_lat[k]) begin
                    m_t[k] = m_t[k] + 1;
                end else if (out_ready_v[k]) begin
                    m_act[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int         n, i, j;
        logic       run, done;
        logic [3:0] ea, eb;
        for (int k = 0; k < 2; k++) begin
            if (m_known[k]) begin
                n    = (k != 0) ? 4 : 2;
                run  = m_act[k] && (m_t[k] < m_lat[k]);
                done = m_act[k] && (m_t[k] >= m_lat[k]);
                ea   = 4'h0;
                eb   = 4'h0;
                if (run) begin
                    i  = m_t[k] / n;
                    j  = m_t[k] % n;
                    ea = 4'((m_a[k] >> (4 * i)) & 16'hF);
                    eb = 4'((m_b[k] >> (4 * j)) & 16'hF);
                end
                chk("in_ready", k, 32'(in_ready_v[k]), 32'(!m_act[k]));
                chk("out_valid", k, 32'(out_valid_v[k]), 32'(done));
                chk("busy", k, 32'(busy_v[k]), 32'(m_act[k]));
                chk("mul_en", k, 32'(mul_en_v[k]), 32'(run));
                chk("mul_ab", k, {24'h0, mul_a_v[k], mul_b_v[k]}, {24'h0, ea, eb});
                if (done) chk("out_prod", k, out_prod_v[k], 32'(m_a[k]) * 32'(m_b[k]));
                if (!m_act[k] && m_clean[k]) chk("prod_after_reset", k, out_prod_v[k], 32'h0);
            end
        end
    end

    logic [7:0] pairs_q[$];

    task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         input int hold, output logic [31:0] prod, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready_v[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_op", k, 32'(in_ready_v[k]), 32'd1);
        in_a_v[k]      = a;
        in_b_v[k]      = b;
        in_valid_v[k]  = 1'b1;
        out_ready_v[k] = (hold == 0);
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        in_a_v[k]     = rnd(k);
        in_b_v[k]     = rnd(k);
        pairs_q.delete();
        lat = 0;
        while (!out_valid_v[k] && lat < 40) begin
            if (mul_en_v[k]) pairs_q.push_back({mul_a_v[k], mul_b_v[k]});
            @(negedge clk);
            lat++;
        end
        chk("out_valid_timeout", k, 32'(out_valid_v[k]), 32'd1);
        prod = out_prod_v[k];
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", k, 32'(out_valid_v[k]), 32'd1);
            chk("hold_prod", k, out_prod_v[k], 32'(a) * 32'(b));
            chk("hold_in_ready", k, 32'(in_ready_v[k]), 32'd0);
            @(negedge clk);
        end
        out_ready_v[k] = 1'b1;
        @(negedge clk);
        chk("release_in_ready", k, 32'(in_ready_v[k]), 32'd1);
        chk("release_out_valid", k, 32'(out_valid_v[k]), 32'd0);
        $display("op w%0d a=%0h b=%0h prod=%0h lat=%0d hold=%0d",
                 (k != 0) ? 16 : 8, a, b, prod, lat, hold);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog w0 got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] p;
        int          l;
        logic [7:0]  seq2 [4];
        logic [15:0] ra, rb;
        seq2 = '{8'h5C, 8'h53, 8'hAC, 8'hA3};

        rst_n       = 1'b0;
        in_valid_v  = 2'b00;
        out_ready_v = 2'b00;
        in_a_v      = '0;
        in_b_v      = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 0, 32'(in_ready_v[0]), 32'd1);
        chk("rst_out_valid", 0, 32'(out_valid_v[0]), 32'd0);
        chk("rst_out_prod", 0, out_prod_v[0], 32'h0);
        chk("rst_mul_ab", 0, {24'h0, mul_a_v[0], mul_b_v[0]}, 32'h0);
        chk("rst_mul_en", 0, 32'(mul_en_v[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
        rst_n = 1'b1;

        do_op(0, 16'h00FF, 16'h00FF, 0, p, l);
        chk("t1_prod", 0, p, 32'h0000FE01);
        chk("t1_latency", 0, 32'(l), 32'd4);
        chk("t1_pair_count", 0, 32'(pairs_q.size()), 32'd4);
        foreach (pairs_q[q]) chk("t1_pair", 0, 32'(pairs_q[q]), 32'h000000FF);

        do_op(0, 16'h00A5, 16'h003C, 0, p, l);
        chk("t2_prod", 0, p, 32'h000026AC);
        chk("t2_pair_count", 0, 32'(pairs_q.size()), 32'd4);
        for (int q = 0; q < pairs_q.size() && q < 4; q++)
            chk("t2_pair", 0, 32'(pairs_q[q]), 32'(seq2[q]));

        do_op(0, 16'h0012, 16'h0034, 3, p, l);
        chk("t3_prod", 0, p, 32'h000003A8);

        @(negedge clk);
        in_a_v[0]     = 16'h00FF;
        in_b_v[0]     = 16'h00FF;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_out_valid", 0, 32'(out_valid_v[0]), 32'd0);
        chk("t4_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("t4_in_ready", 0, 32'(in_ready_v[0]), 32'd1);
        rst_n = 1'b1;
        do_op(0, 16'h0003, 16'h0005, 0, p, l);
        chk("t4_prod", 0, p, 32'h0000000F);

        do_op(0, 16'h0000, 16'h007F, 0, p, l);
        chk("t5_prod", 0, p, 32'h0);
`ifdef MULT_NIBBLE_ZERO_SKIP_EN
        chk("t5_latency", 0, 32'(l), 32'd0);
        chk("t5_pair_count", 0, 32'(pairs_q.size()), 32'd0);
`else
        chk("t5_latency", 0, 32'(l), 32'd4);
        chk("t5_pair_count", 0, 32'(pairs_q.size()), 32'd4);
`endif

        do_op(1, 16'hFFFF, 16'hFFFF, 0, p, l);
        chk("t6_prod", 1, p, 32'hFFFE0001);
        chk("t6_latency", 1, 32'(l), 32'd16);

        for (int r = 0; r < 300; r++) begin
            ra = rnd(0);
            rb = rnd(0);
            do_op(0, ra, rb, $urandom_range(0, 2), p, l);
            chk("rand8_prod", 0, p, 32'(ra) * 32'(rb));
            chk("rand8_latency", 0, 32'(l), 32'(exp_latency(0, ra, rb)));
        end
        for (int r = 0; r < 1000; r++) begin
            ra = rnd(1);
            rb = rnd(1);
            do_op(1, ra, rb, $urandom_range(0, 2), p, l);
            chk("rand16_prod", 1, p, 32'(ra) * 32'(rb));
            chk("rand16_latency", 1, 32'(l), 32'(exp_latency(1, ra, rb)));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
